reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard.sv | 99 +++++++++
 tb/tb_reg_scoreboard.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that stall issue on
// RAW (and optionally WAW) hazards and are released by writeback or flush.
module reg_scoreboard #(
    parameter int NREG        = 31,
    parameter int MAX_PENDING = 3,
    parameter bit STALL_WAW   = 1'b0,
    parameter bit WB_BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            issue_valid,
    input  logic [NREG-1:0] issue_rmask,
    input  logic [NREG-1:0] issue_wmask,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [NREG-1:0] wb_wmask,
    input  logic            flush_valid,
    input  logic [NREG-1:0] flush_wmask,
    output logic [NREG-1:0] busy_mask,
    output logic            stall,
    output logic            idle,
    output logic            err_underflow
);
    localparam int            CW      = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            err_underflow_q;
    logic            err_underflow_d;

    logic [NREG-1:0] dec_wb;
    logic [NREG-1:0] dec_fl;
    logic [NREG-1:0] rel;
    logic [NREG-1:0] nonzero;
    logic [NREG-1:0] eb;
    logic [NREG-1:0] full;
    logic [NREG-1:0] inc;

    always_comb begin : hazard
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nonzero = '0;
        eb      = '0;
        full    = '0;
        dec_wb  = wb_valid    ? wb_wmask    : '0;
        dec_fl  = flush_valid ? flush_wmask : '0;
        rel     = dec_wb | dec_fl;
        for (int i = 0; i < NREG; i++) begin
            nonzero[i] = (cnt_q[i] != '0);
            // A register whose last pending write retires now may be read this cycle.
            eb[i]      = nonzero[i] & ~(WB_BYPASS & (cnt_q[i] == CNT_ONE) & rel[i]);
            full[i]    = (cnt_q[i] == CNT_MAX) & ~rel[i];
        end
        issue_ready = ~|(issue_rmask & eb)
                    & ~|(issue_wmask & full)
                    & ~(STALL_WAW & (|(issue_wmask & eb)))
                    & ~flush_valid;
    end

    assign inc = (issue_valid && issue_ready) ? issue_wmask : '0;

    always_comb begin : next_count
        int sum;
        sum             = 0;
        cnt_d           = cnt_q;
        err_underflow_d = err_underflow_q;
        for (int i = 0; i < NREG; i++) begin
            sum = int'(cnt_q[i]) + int'(inc[i]) - int'(dec_wb[i]) - int'(dec_fl[i]);
            if (sum < 0) begin
                cnt_d[i]        = '0;
                err_underflow_d = 1'b1;
            end else begin
                cnt_d[i] = CW'(sum);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the counter array is plain flops and must be cleared on reset; stale
            // pending counts would stall issue forever.
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            err_underflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            cnt_q           <= cnt_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign busy_mask     = eb;
    assign idle          = ~|nonzero;
    assign stall         = issue_valid & ~issue_ready;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios plus randomized traffic against
// a per-register integer-count model, on a default instance and a WAW/no-bypass one.
module tb_reg_scoreboard;
    localparam int NREG  = 31;
    localparam int MAXP  = 3;
    localparam int NRAND = 600;

    localparam logic [NREG-1:0] NONE = '0;
    localparam logic [NREG-1:0] R2   = NREG'(1) << 1;
    localparam logic [NREG-1:0] R3   = NREG'(1) << 2;
    localparam logic [NREG-1:0] R5   = NREG'(1) << 4;
    localparam logic [NREG-1:0] R7   = NREG'(1) << 6;
    localparam logic [NREG-1:0] R11  = NREG'(1) << 10;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic            issue_valid = 1'b0;
    logic [NREG-1:0] issue_rmask = '0;
    logic [NREG-1:0] issue_wmask = '0;
    logic            wb_valid = 1'b0;
    logic [NREG-1:0] wb_wmask = '0;
    logic            flush_valid = 1'b0;
    logic [NREG-1:0] flush_wmask = '0;

    logic            a_ready, a_stall, a_idle, a_err;
    logic [NREG-1:0] a_busy;
    logic            b_ready, b_stall, b_idle, b_err;
    logic [NREG-1:0] b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 = default instance, index 1 = STALL_WAW=1, WB_BYPASS=0.
    int m_cnt [2][NREG];
    bit m_err [2];
    bit m_waw [2] = '{1'b0, 1'b1};
    bit m_byp [2] = '{1'b1, 1'b0};

    reg_scoreboard #(.NREG(NREG), .MAX_PENDING(MAXP), .STALL_WAW(1'b0), .WB_BYPASS(1'b1)) dut_a (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_rmask(issue_rmask), .issue_wmask(issue_wmask),
        .issue_ready(a_ready),
        .wb_valid(wb_valid), .wb_wmask(wb_wmask),
        .flush_valid(flush_valid), .flush_wmask(flush_wmask),
        .busy_mask(a_busy), .stall(a_stall), .idle(a_idle), .err_underflow(a_err)
    );

    reg_scoreboard #(.NREG(NREG), .MAX_PENDING(MAXP), .STALL_WAW(1'b1), .WB_BYPASS(1'b0)) dut_b (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_rmask(issue_rmask), .issue_wmask(issue_wmask),
        .issue_ready(b_ready),
        .wb_valid(wb_valid), .wb_wmask(wb_wmask),
        .flush_valid(flush_valid), .flush_wmask(flush_wmask),
        .busy_mask(b_busy), .stall(b_stall), .idle(b_idle), .err_underflow(b_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NREG-1:0] rel_mask();
        return (wb_valid ? wb_wmask : NONE) | (flush_valid ? flush_wmask : NONE);
    endfunction

    function automatic bit reg_busy(int m, int i);
        logic [NREG-1:0] rel = rel_mask();
        if (m_cnt[m][i] == 0) return 1'b0;
        if (m_byp[m] && m_cnt[m][i] == 1 && rel[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_ready(int m);
        logic [NREG-1:0] rel = rel_mask();
        if (flush_valid) return 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (issue_rmask[i] && reg_busy(m, i)) return 1'b0;
            if (issue_wmask[i] && m_cnt[m][i] == MAXP && !rel[i]) return 1'b0;
            if (m_waw[m] && issue_wmask[i] && reg_busy(m, i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NREG-1:0] exp_nonzero(int m);
        logic [NREG-1:0] r = '0;
        for (int i = 0; i < NREG; i++) r[i] = (m_cnt[m][i] != 0);
        return r;
    endfunction

    task automatic drive(input logic iv, input logic [NREG-1:0] rm, input logic [NREG-1:0] wm,
                         input logic wv, input logic [NREG-1:0] wbm,
                         input logic fv, input logic [NREG-1:0] fm);
        issue_valid = iv;  issue_rmask = rm;  issue_wmask = wm;
        wb_valid    = wv;  wb_wmask    = wbm;
        flush_valid = fv;  flush_wmask = fm;
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, NONE, NONE, 1'b0, NONE, 1'b0, NONE);
    endtask

    // Clock edge plus model update using the inputs held across the edge.
    task automatic tick();
        bit rdy [2];
        int n;
        for (int m = 0; m < 2; m++) rdy[m] = exp_ready(m);
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NREG; i++) begin
                n = m_cnt[m][i];
                if (issue_valid && rdy[m] && issue_wmask[i]) n++;
                if (wb_valid && wb_wmask[i]) n--;
                if (flush_valid && flush_wmask[i]) n--;
                if (n < 0) begin
                    n = 0;
                    m_err[m] = 1'b1;
                end
                m_cnt[m][i] = n;
            end
        end
        #1;
    endtask

    task automatic clear_model();
        for (int m = 0; m < 2; m++) begin
            m_err[m] = 1'b0;
            for (int i = 0; i < NREG; i++) m_cnt[m][i] = 0;
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 1'b0;
        clear_model();
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        clear_model();
        #2;
        n_checks++; if (a_busy !== NONE) begin n_fail++; $display("FAIL por_busy: got %h expected 0", a_busy); end
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL por_idle: got %b expected 1", a_idle); end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL por_ready: got %b expected 1", a_ready); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL por_err: got %b expected 0", a_err); end
        resetn = 1'b1;
        drive(1'b1, NONE, R5, 1'b0, NONE, 1'b0, NONE);
        tick();
        drive(1'b0, NONE, NONE, 1'b1, R11, 1'b0, NONE);
        tick();
        drive(1'b1, R5, NONE, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %b expected 1", a_stall); end
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_err: got %b expected 1", a_err); end
        #2 resetn = 1'b0;
        clear_model();
        #1;
        n_checks++; if (a_busy !== NONE) begin n_fail++; $display("FAIL async_busy: got %h expected 0", a_busy); end
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL async_idle: got %b expected 1", a_idle); end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b expected 1", a_ready); end
        n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL async_stall: got %b expected 0", a_stall); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL async_err: got %b expected 0", a_err); end
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
    endtask

    task automatic test_raw();
        apply_reset();
        drive(1'b1, NONE, R5, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b expected 1", a_ready); end
        tick();
        drive(1'b1, R5, NONE, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b expected 1", a_stall); end
        n_checks++; if (a_busy !== R5) begin n_fail++; $display("FAIL raw_busy: got %h expected %h", a_busy, R5); end
        drive(1'b1, R5, NONE, 1'b1, R5, 1'b0, NONE);
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_ready: got %b expected 1", a_ready); end
        tick();
        idle_inputs();
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL raw_released_idle: got %b expected 1", a_idle); end
        drive(1'b1, NONE, R5, 1'b0, NONE, 1'b0, NONE);
        tick();
        drive(1'b1, R5, R5, 1'b1, R5, 1'b0, NONE);
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_rewrite_ready: got %b expected 1", a_ready); end
        tick();
        idle_inputs();
        n_checks++; if (a_busy !== R5) begin n_fail++; $display("FAIL raw_rewrite_busy: got %h expected %h", a_busy, R5); end
        drive(1'b0, NONE, NONE, 1'b1, R5, 1'b0, NONE);
        tick();
        idle_inputs();
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL raw_final_idle: got %b expected 1", a_idle); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL raw_err: got %b expected 0", a_err); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < MAXP; k++) begin
            drive(1'b1, NONE, R7, 1'b0, NONE, 1'b0, NONE);
            n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue%0d: got %b expected 1", k, a_ready); end
            tick();
        end
        drive(1'b1, NONE, R7, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL sat_full_stall: got %b expected 1", a_stall); end
        drive(1'b1, NONE, R7, 1'b1, R7, 1'b0, NONE);
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL sat_release_ready: got %b expected 1", a_ready); end
        tick();
        drive(1'b1, NONE, R7, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL sat_still_full: got %b expected 0", a_ready); end
        for (int k = 0; k < MAXP - 1; k++) begin
            drive(1'b0, NONE, NONE, 1'b1, R7, 1'b0, NONE);
            tick();
        end
        idle_inputs();
        n_checks++; if (a_busy !== R7) begin n_fail++; $display("FAIL sat_one_left: got %h expected %h", a_busy, R7); end
        drive(1'b0, NONE, NONE, 1'b1, R7, 1'b0, NONE);
        tick();
        idle_inputs();
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL sat_drained_idle: got %b expected 1", a_idle); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL sat_err: got %b expected 0", a_err); end
    endtask

    task automatic test_waw();
        apply_reset();
        drive(1'b1, NONE, R2, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL waw_first: got %b expected 1", b_ready); end
        tick();
        drive(1'b1, NONE, R2, 1'b0, NONE, 1'b0, NONE);
        n_checks++; if (b_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b expected 1", b_stall); end
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL waw_off_issue: got %b expected 1", a_ready); end
        tick();
        drive(1'b1, R2, NONE, 1'b1, R2, 1'b0, NONE);
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL waw_cnt2_raw: got %b expected 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL nobypass_raw: got %b expected 0", b_ready); end
        tick();
        idle_inputs();
        n_checks++; if (a_busy !== R2) begin n_fail++; $display("FAIL waw_cnt_left: got %h expected %h", a_busy, R2); end
        n_checks++; if (b_idle !== 1'b1) begin n_fail++; $display("FAIL nobypass_idle: got %b expected 1", b_idle); end
        drive(1'b0, NONE, NONE, 1'b1, R2, 1'b0, NONE);
        tick();
        idle_inputs();
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL waw_final_idle: got %b expected 1", a_idle); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL waw_a_err: got %b expected 0", a_err); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL waw_b_underflow: got %b expected 1", b_err); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, NONE, R3, 1'b0, NONE, 1'b0, NONE);
            tick();
        end
        drive(1'b1, NONE, NONE, 1'b1, R3, 1'b1, R3);
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", a_ready); end
        n_checks++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall: got %b expected 1", a_stall); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL flush_b_ready: got %b expected 0", b_ready); end
        tick();
        idle_inputs();
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %b expected 1", a_idle); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL flush_a_err: got %b expected 0", a_err); end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL flush_b_underflow: got %b expected 1", b_err); end
        drive(1'b1, NONE, NONE, 1'b0, NONE, 1'b1, NONE);
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL flush_empty_ready: got %b expected 0", a_ready); end
        tick();
    endtask

    task automatic test_underflow();
        apply_reset();
        drive(1'b0, NONE, NONE, 1'b1, R11, 1'b0, NONE);
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL uf_not_yet: got %b expected 0", a_err); end
        tick();
        idle_inputs();
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b expected 1", a_err); end
        n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL uf_idle: got %b expected 1", a_idle); end
        for (int k = 0; k < 3; k++) tick();
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", a_err); end
        #2 resetn = 1'b0;
        clear_model();
        #1;
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL uf_reset_clear: got %b expected 0", a_err); end
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
    endtask

    function automatic logic [NREG-1:0] rand_mask();
        logic [NREG-1:0] r = '0;
        for (int k = 0; k < 2; k++) if ($urandom_range(0, 1) == 1) r[$urandom_range(0, 7)] = 1'b1;
        if ($urandom_range(0, 9) == 0) r[$urandom_range(0, NREG - 1)] = 1'b1;
        return r;
    endfunction

    function automatic logic [NREG-1:0] rand_release();
        logic [NREG-1:0] r = '0;
        for (int i = 0; i < NREG; i++) if (m_cnt[0][i] > 0 && $urandom_range(0, 2) == 0) r[i] = 1'b1;
        if ($urandom_range(0, 19) == 0) r[$urandom_range(0, NREG - 1)] = 1'b1;
        return r;
    endfunction

    task automatic test_random();
        logic            o_ready [2];
        logic            o_stall [2];
        logic            o_idle  [2];
        logic            o_err   [2];
        logic [NREG-1:0] o_busy  [2];
        logic [NREG-1:0] rel;
        bit              er;
        apply_reset();
        for (int c = 0; c < NRAND; c++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            drive($urandom_range(0, 3) != 0, rand_mask(), rand_mask(),
                  $urandom_range(0, 2) == 0, rand_release(),
                  $urandom_range(0, 11) == 0, rand_release());
            o_ready = '{a_ready, b_ready};
            o_stall = '{a_stall, b_stall};
            o_idle  = '{a_idle, b_idle};
            o_err   = '{a_err, b_err};
            o_busy  = '{a_busy, b_busy};
            rel = rel_mask();
            for (int m = 0; m < 2; m++) begin
                er = exp_ready(m);
                n_checks++; if (o_ready[m] !== er) begin n_fail++; $display("FAIL rnd_ready[%0d] cyc %0d: got %b expected %b", m, c, o_ready[m], er); end
                n_checks++; if (o_stall[m] !== (issue_valid & ~er)) begin n_fail++; $display("FAIL rnd_stall[%0d] cyc %0d: got %b expected %b", m, c, o_stall[m], issue_valid & ~er); end
                n_checks++; if (o_idle[m] !== (exp_nonzero(m) == NONE)) begin n_fail++; $display("FAIL rnd_idle[%0d] cyc %0d: got %b expected %b", m, c, o_idle[m], exp_nonzero(m) == NONE); end
                n_checks++; if (o_err[m] !== m_err[m]) begin n_fail++; $display("FAIL rnd_err[%0d] cyc %0d: got %b expected %b", m, c, o_err[m], m_err[m]); end
                n_checks++; if ((o_busy[m] & ~rel) !== (exp_nonzero(m) & ~rel)) begin n_fail++; $display("FAIL rnd_busy[%0d] cyc %0d: got %h expected %h", m, c, o_busy[m] & ~rel, exp_nonzero(m) & ~rel); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_saturation();
        test_waw();
        test_flush();
        test_underflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
